xm23_mem_arbiter: RTL and testbench

Arbitrates the single byte-laned XM23 RAM between two requesters: the CPU's MAR/MDR path and the debug/loader port used by the data viewer and program loader. It sequences each access through issue, capture and acknowledge states. It drives the RAM's split lower-byte and upper-byte address, data and write-enable lanes. It returns read data and status to the granted requester. It sits between the CPU datapath bus logic and the `memory` instance.

---
 rtl/xm23_mem_pkg.sv | 28 ++
 rtl/xm23_mem_arb_aging.sv | 34 +++
 rtl/xm23_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_xm23_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xm23_mem_pkg.sv
// Shared encodings for the XM23 memory arbiter: FSM states, owner IDs,
// access sizes and the latched request record.
package xm23_mem_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam logic ACC_WORD = 1'b0;
  localparam logic ACC_BYTE = 1'b1;

  typedef struct packed {
    logic        we;
    logic        size;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_req_t;

  // Word accesses must be even-aligned; byte accesses may use any address.
  function automatic logic is_misaligned(input logic size, input logic [15:0] addr);
    return (size == ACC_WORD) && addr[0];
  endfunction

endpackage

// File: rtl/xm23_mem_arb_aging.sv
// Starvation counter for the debug port: counts arbitrations the debug port
// loses and raises force_dbg once the count reaches STARVE_LIMIT.
module xm23_mem_arb_aging
  #(parameter int STARVE_LIMIT = 4)
  (
    input  logic Clock,
    input  logic Reset,
    input  logic arb_cycle,
    input  logic dbg_pending,
    input  logic dbg_granted,
    output logic force_dbg
  );

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;

  // Saturates at LIMIT so force_dbg stays asserted until debug is served.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      starve_cnt <= '0;
    end else if (arb_cycle) begin
      if (dbg_granted) begin
        starve_cnt <= '0;
      end else if (dbg_pending && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign force_dbg = (starve_cnt >= LIMIT);

endmodule

// File: rtl/xm23_mem_arbiter.sv
// Two-port arbiter (CPU, debug/loader) in front of the byte-laned XM23 RAM.
// Define XM23_MEM_ARB_STARVE_EN to enable debug-port anti-starvation aging.
module xm23_mem_arbiter
  import xm23_mem_pkg::*;
  #(parameter int STARVE_LIMIT = 4)
  (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic        dbg_byte,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic [15:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        dbg_err,
    output logic [15:0] mem_lb_addr,
    output logic [15:0] mem_ub_addr,
    output logic [7:0]  mem_lb_wdata,
    output logic [7:0]  mem_ub_wdata,
    output logic        mem_lb_we,
    output logic        mem_ub_we,
    input  logic [7:0]  mem_lb_q,
    input  logic [7:0]  mem_ub_q,
    output logic        busy,
    output logic        gnt_dbg
  );

  logic [1:0]  state;
  logic        owner;
  logic        cur_we;
  logic        cur_size;
  logic        err_q;
  logic        arb_cycle;
  logic        pick_dbg;
  logic        force_dbg;
  logic [15:0] rd_word;
  mem_req_t    cpu_fields;
  mem_req_t    dbg_fields;
  mem_req_t    win;

  assign cpu_fields = '{we: cpu_we, size: cpu_byte, addr: cpu_addr, wdata: cpu_wdata};
  assign dbg_fields = '{we: dbg_we, size: dbg_byte, addr: dbg_addr, wdata: dbg_wdata};

  // CPU wins ties unless the aging logic says debug has waited long enough.
  assign arb_cycle = (state == ST_IDLE) && (cpu_req || dbg_req);
  assign pick_dbg  = dbg_req && (!cpu_req || force_dbg);
  assign win       = pick_dbg ? dbg_fields : cpu_fields;

`ifdef XM23_MEM_ARB_STARVE_EN
  xm23_mem_arb_aging #(.STARVE_LIMIT(STARVE_LIMIT)) u_aging (
    .Clock       (Clock),
    .Reset       (Reset),
    .arb_cycle   (arb_cycle),
    .dbg_pending (dbg_req),
    .dbg_granted (pick_dbg),
    .force_dbg   (force_dbg)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
  assign force_dbg = 1'b0;
`endif

  assign rd_word = (cur_size == ACC_BYTE) ? {8'h00, mem_lb_q} : {mem_ub_q, mem_lb_q};

  // RAM lanes are loaded on the grant edge so they are valid throughout ISSUE;
  // the write enables self-clear so they are high for exactly that cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= ST_IDLE;
      owner        <= OWN_CPU;
      cur_we       <= 1'b0;
      cur_size     <= ACC_WORD;
      err_q        <= 1'b0;
      gnt_dbg      <= 1'b0;
      cpu_rdata    <= '0;
      dbg_rdata    <= '0;
      mem_lb_addr  <= '0;
      mem_ub_addr  <= '0;
      mem_lb_wdata <= '0;
      mem_ub_wdata <= '0;
      mem_lb_we    <= 1'b0;
      mem_ub_we    <= 1'b0;
    end else begin
      mem_lb_we <= 1'b0;
      mem_ub_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arb_cycle) begin
            owner    <= pick_dbg;
            gnt_dbg  <= pick_dbg;
            cur_we   <= win.we;
            cur_size <= win.size;
            if (is_misaligned(win.size, win.addr)) begin
              err_q <= 1'b1;
              state <= ST_ACK;
            end else begin
              err_q        <= 1'b0;
              state        <= ST_ISSUE;
              mem_lb_addr  <= win.addr;
              mem_ub_addr  <= win.addr + 16'd1;
              mem_lb_wdata <= win.wdata[7:0];
              mem_ub_wdata <= win.wdata[15:8];
              mem_lb_we    <= win.we;
              mem_ub_we    <= win.we && (win.size == ACC_WORD);
            end
          end
        end
        ST_ISSUE: begin
          state <= cur_we ? ST_ACK : ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (owner == OWN_DBG) begin
            dbg_rdata <= rd_word;
          end else begin
            cpu_rdata <= rd_word;
          end
          state <= ST_ACK;
        end
        ST_ACK: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign cpu_ack = (state == ST_ACK) && (owner == OWN_CPU);
  assign dbg_ack = (state == ST_ACK) && (owner == OWN_DBG);
  assign cpu_err = cpu_ack && err_q;
  assign dbg_err = dbg_ack && err_q;

endmodule

// File: tb/tb_xm23_mem_arbiter.sv
// Self-checking bench for xm23_mem_arbiter: directed vector table, hand-written
// arbitration/reset sequences and randomized accesses against a byte-array model.
module tb_xm23_mem_arbiter;
  import xm23_mem_pkg::*;

  localparam int STARVE_LIMIT = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, cpu_byte;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_err;
  logic        dbg_req, dbg_we, dbg_byte;
  logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_ack, dbg_err;
  logic [15:0] mem_lb_addr, mem_ub_addr;
  logic [7:0]  mem_lb_wdata, mem_ub_wdata;
  logic        mem_lb_we, mem_ub_we;
  logic [7:0]  mem_lb_q, mem_ub_q;
  logic        busy, gnt_dbg;

  int n_vec = 0;
  int n_bad = 0;

  xm23_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .Clock(Clock), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_byte(dbg_byte), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
    .mem_lb_addr(mem_lb_addr), .mem_ub_addr(mem_ub_addr),
    .mem_lb_wdata(mem_lb_wdata), .mem_ub_wdata(mem_ub_wdata),
    .mem_lb_we(mem_lb_we), .mem_ub_we(mem_ub_we),
    .mem_lb_q(mem_lb_q), .mem_ub_q(mem_ub_q),
    .busy(busy), .gnt_dbg(gnt_dbg)
  );

  always #5 Clock = ~Clock;

  // Byte-array RAM with registered read data, one cycle after the address.
  logic [7:0] ram [0:65535];
  always @(posedge Clock) begin
    if (mem_lb_we) ram[mem_lb_addr] <= mem_lb_wdata;
    if (mem_ub_we) ram[mem_ub_addr] <= mem_ub_wdata;
    mem_lb_q <= ram[mem_lb_addr];
    mem_ub_q <= ram[mem_ub_addr];
  end

  logic [7:0]  ref_mem   [0:65535];
  logic [15:0] ref_rdata [0:1];

  typedef struct {
    logic        port;
    logic        we;
    logic        bsz;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic        err;
    logic [15:0] rdata;
    logic        lb_we;
    logic        ub_we;
    logic [7:0]  lb_wd;
    logic [7:0]  ub_wd;
    logic [15:0] lb_addr;
    logic [15:0] ub_addr;
  } vec_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [15:0] rdata;
    logic        lb_we;
    logic        ub_we;
    logic [7:0]  lb_wd;
    logic [7:0]  ub_wd;
    logic [15:0] lb_addr;
    logic [15:0] ub_addr;
    logic        stray_we;
    logic        other_ack;
  } obs_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Reference: RAM as a byte array, per-port last read value, errors for odd word addresses.
  task automatic modelApply(input logic port, input logic we, input logic bsz,
                            input logic [15:0] addr, input logic [15:0] wdata,
                            output logic [15:0] exp_rd, output logic exp_err);
    logic [15:0] addr1;
    addr1   = addr + 16'd1;
    exp_err = (bsz == ACC_WORD) && (addr[0] == 1'b1);
    if (!exp_err) begin
      if (we) begin
        ref_mem[addr] = wdata[7:0];
        if (bsz == ACC_WORD) ref_mem[addr1] = wdata[15:8];
      end else if (bsz == ACC_BYTE) begin
        ref_rdata[port] = {8'h00, ref_mem[addr]};
      end else begin
        ref_rdata[port] = {ref_mem[addr1], ref_mem[addr]};
      end
    end
    exp_rd = ref_rdata[port];
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic bsz,
                               input logic [15:0] addr, input logic [15:0] wdata, output obs_t o);
    logic done;
    o = '{default: 0};
    done = 1'b0;
    @(negedge Clock);
    if (port == OWN_DBG) begin
      dbg_we = we; dbg_byte = bsz; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1'b1;
    end else begin
      cpu_we = we; cpu_byte = bsz; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge Clock);
      if (c == 1) begin
        o.lb_we = mem_lb_we;       o.ub_we = mem_ub_we;
        o.lb_wd = mem_lb_wdata;    o.ub_wd = mem_ub_wdata;
        o.lb_addr = mem_lb_addr;   o.ub_addr = mem_ub_addr;
      end else if (mem_lb_we || mem_ub_we) begin
        o.stray_we = 1'b1;
      end
      if ((port == OWN_DBG) ? cpu_ack : dbg_ack) o.other_ack = 1'b1;
      if ((port == OWN_DBG) ? dbg_ack : cpu_ack) begin
        o.lat   = c;
        o.err   = (port == OWN_DBG) ? dbg_err : cpu_err;
        o.rdata = (port == OWN_DBG) ? dbg_rdata : cpu_rdata;
        done    = 1'b1;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
  endtask

  initial begin
    obs_t        o;
    logic [15:0] exp_rd;
    logic        exp_err;
    logic        rp, rwe, rbsz;
    logic [15:0] raddr, rwd;
    int          cpu_at, dbg_at;
    logic        gnt_first, gnt_last;
    logic [15:0] dbg_rd_seen;
    int          winners [$];
    int          gnts [$];
    int          w, g, exp_w;

    Reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_byte = 0; dbg_addr = 0; dbg_wdata = 0;
    ref_rdata[0] = 16'h0000;
    ref_rdata[1] = 16'h0000;

    vecs[0]  = '{OWN_CPU, 1'b1, ACC_WORD, 16'h0100, 16'hBEEF, 2, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hEF, 8'hBE, 16'h0100, 16'h0101};
    vecs[1]  = '{OWN_CPU, 1'b0, ACC_WORD, 16'h0100, 16'h0000, 3, 1'b0, 16'hBEEF, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0100, 16'h0101};
    vecs[2]  = '{OWN_DBG, 1'b1, ACC_BYTE, 16'h0101, 16'h0077, 2, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h77, 8'h00, 16'h0101, 16'h0102};
    vecs[3]  = '{OWN_DBG, 1'b0, ACC_WORD, 16'h0100, 16'h0000, 3, 1'b0, 16'h77EF, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0100, 16'h0101};
    vecs[4]  = '{OWN_CPU, 1'b0, ACC_WORD, 16'h0003, 16'h0000, 1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0100, 16'h0101};
    vecs[5]  = '{OWN_CPU, 1'b1, ACC_WORD, 16'hFFFE, 16'hA55A, 2, 1'b0, 16'hBEEF, 1'b1, 1'b1, 8'h5A, 8'hA5, 16'hFFFE, 16'hFFFF};
    vecs[6]  = '{OWN_CPU, 1'b0, ACC_BYTE, 16'hFFFF, 16'h0000, 3, 1'b0, 16'h00A5, 1'b0, 1'b0, 8'h00, 8'h00, 16'hFFFF, 16'h0000};
    vecs[7]  = '{OWN_DBG, 1'b0, ACC_WORD, 16'hFFFE, 16'h0000, 3, 1'b0, 16'hA55A, 1'b0, 1'b0, 8'h00, 8'h00, 16'hFFFE, 16'hFFFF};
    vecs[8]  = '{OWN_DBG, 1'b1, ACC_WORD, 16'h0005, 16'h1234, 1, 1'b1, 16'hA55A, 1'b0, 1'b0, 8'h00, 8'h00, 16'hFFFE, 16'hFFFF};
    vecs[9]  = '{OWN_CPU, 1'b1, ACC_BYTE, 16'h0100, 16'h12C3, 2, 1'b0, 16'h00A5, 1'b1, 1'b0, 8'hC3, 8'h12, 16'h0100, 16'h0101};
    vecs[10] = '{OWN_DBG, 1'b0, ACC_BYTE, 16'h0101, 16'h0000, 3, 1'b0, 16'h0077, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0101, 16'h0102};
    vecs[11] = '{OWN_CPU, 1'b0, ACC_WORD, 16'h0100, 16'h0000, 3, 1'b0, 16'h77C3, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0100, 16'h0101};

    repeat (3) @(negedge Clock);
    checkOutput("reset outputs zero",
                32'(|{cpu_rdata, cpu_ack, cpu_err, dbg_rdata, dbg_ack, dbg_err, mem_lb_addr, mem_ub_addr,
                      mem_lb_wdata, mem_ub_wdata, mem_lb_we, mem_ub_we, busy, gnt_dbg}), 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].bsz, vecs[i].addr, vecs[i].wdata, o);
      modelApply(vecs[i].port, vecs[i].we, vecs[i].bsz, vecs[i].addr, vecs[i].wdata, exp_rd, exp_err);
      checkOutput($sformatf("vec%0d latency", i), 32'(o.lat), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d err", i), 32'(o.err), 32'(vecs[i].err));
      checkOutput($sformatf("vec%0d rdata", i), 32'(o.rdata), 32'(vecs[i].rdata));
      checkOutput($sformatf("vec%0d we lanes", i), {30'd0, o.lb_we, o.ub_we}, {30'd0, vecs[i].lb_we, vecs[i].ub_we});
      checkOutput($sformatf("vec%0d addr lanes", i), {o.lb_addr, o.ub_addr}, {vecs[i].lb_addr, vecs[i].ub_addr});
      checkOutput($sformatf("vec%0d stray we/ack", i), {30'd0, o.stray_we, o.other_ack}, 32'd0);
      if (vecs[i].we && !vecs[i].err)
        checkOutput($sformatf("vec%0d wdata lanes", i), {16'd0, o.lb_wd, o.ub_wd}, {16'd0, vecs[i].lb_wd, vecs[i].ub_wd});
    end

    // Simultaneous requests: CPU write served first, debug read on the next arbitration.
    @(negedge Clock);
    cpu_we = 1; cpu_byte = ACC_WORD; cpu_addr = 16'h0200; cpu_wdata = 16'h1111; cpu_req = 1;
    dbg_we = 0; dbg_byte = ACC_WORD; dbg_addr = 16'h0200; dbg_wdata = 16'h0000; dbg_req = 1;
    cpu_at = 0; dbg_at = 0; gnt_first = 1'b1; gnt_last = 1'b0; dbg_rd_seen = 16'h0000;
    for (int c = 1; c <= 20 && dbg_at == 0; c++) begin
      @(negedge Clock);
      if (c == 1) gnt_first = gnt_dbg;
      if (cpu_ack && cpu_at == 0) begin cpu_at = c; cpu_req = 0; end
      if (dbg_ack) begin dbg_at = c; gnt_last = gnt_dbg; dbg_rd_seen = dbg_rdata; dbg_req = 0; end
    end
    cpu_req = 0; dbg_req = 0;
    modelApply(OWN_CPU, 1'b1, ACC_WORD, 16'h0200, 16'h1111, exp_rd, exp_err);
    modelApply(OWN_DBG, 1'b0, ACC_WORD, 16'h0200, 16'h0000, exp_rd, exp_err);
    checkOutput("simul cpu ack cycle", 32'(cpu_at), 32'd2);
    checkOutput("simul dbg ack cycle", 32'(dbg_at), 32'd6);
    checkOutput("simul gnt_dbg first", 32'(gnt_first), 32'd0);
    checkOutput("simul gnt_dbg second", 32'(gnt_last), 32'd1);
    checkOutput("simul dbg rdata", 32'(dbg_rd_seen), 32'(exp_rd));

    // Both ports requesting writes continuously; record who wins each arbitration.
    @(negedge Clock);
    cpu_we = 1; cpu_byte = ACC_WORD; cpu_addr = 16'h0300; cpu_wdata = 16'hC0C0; cpu_req = 1;
    dbg_we = 1; dbg_byte = ACC_WORD; dbg_addr = 16'h0302; dbg_wdata = 16'hD0D0; dbg_req = 1;
    for (int c = 0; c < 80 && winners.size() < 10; c++) begin
      @(negedge Clock);
      if (cpu_ack) begin
        winners.push_back(0); gnts.push_back(int'(gnt_dbg));
        modelApply(OWN_CPU, 1'b1, ACC_WORD, 16'h0300, 16'hC0C0, exp_rd, exp_err);
      end
      if (dbg_ack) begin
        winners.push_back(1); gnts.push_back(int'(gnt_dbg));
        modelApply(OWN_DBG, 1'b1, ACC_WORD, 16'h0302, 16'hD0D0, exp_rd, exp_err);
      end
    end
    cpu_req = 0; dbg_req = 0;
    for (int k = 1; k <= 10; k++) begin
`ifdef XM23_MEM_ARB_STARVE_EN
      exp_w = ((k % (STARVE_LIMIT + 1)) == 0) ? 1 : 0;
`else
      exp_w = 0;
`endif
      w = (k <= winners.size()) ? winners[k-1] : 2;
      g = (k <= gnts.size()) ? gnts[k-1] : 2;
      checkOutput($sformatf("contend winner %0d", k), 32'(w), 32'(exp_w));
      checkOutput($sformatf("contend gnt_dbg %0d", k), 32'(g), 32'(exp_w));
    end

    // Reset while a CPU read sits in CAPTURE: no ack, everything cleared.
    @(negedge Clock);
    cpu_we = 0; cpu_byte = ACC_WORD; cpu_addr = 16'h0100; cpu_req = 1;
    repeat (2) @(negedge Clock);
    checkOutput("midreset busy before", 32'(busy), 32'd1);
    Reset = 1'b1;
    cpu_req = 0;
    @(negedge Clock);
    checkOutput("midreset ack", {30'd0, cpu_ack, dbg_ack}, 32'd0);
    checkOutput("midreset outputs zero",
                32'(|{cpu_rdata, cpu_ack, cpu_err, dbg_rdata, dbg_ack, dbg_err, mem_lb_addr, mem_ub_addr,
                      mem_lb_wdata, mem_ub_wdata, mem_lb_we, mem_ub_we, busy, gnt_dbg}), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("midreset ack after", {30'd0, cpu_ack, dbg_ack}, 32'd0);
    ref_rdata[0] = 16'h0000;
    ref_rdata[1] = 16'h0000;
    applyStimulus(OWN_CPU, 1'b0, ACC_WORD, 16'h0100, 16'h0000, o);
    modelApply(OWN_CPU, 1'b0, ACC_WORD, 16'h0100, 16'h0000, exp_rd, exp_err);
    checkOutput("post-reset read latency", 32'(o.lat), 32'd3);
    checkOutput("post-reset read rdata", 32'(o.rdata), 32'(exp_rd));

    // Fill the random window so every later read hits known bytes.
    for (int i = 0; i < 16; i++) begin
      raddr = (i < 8) ? (16'h0400 + 16'(i)) : (16'hFFF8 + 16'(i - 8));
      rwd   = 16'($urandom);
      rp    = 1'(i % 2);
      applyStimulus(rp, 1'b1, ACC_BYTE, raddr, rwd, o);
      modelApply(rp, 1'b1, ACC_BYTE, raddr, rwd, exp_rd, exp_err);
      checkOutput($sformatf("fill %0h latency", raddr), 32'(o.lat), 32'd2);
    end

    for (int i = 0; i < 60; i++) begin
      rp    = 1'($urandom_range(0, 1));
      rwe   = 1'($urandom_range(0, 1));
      rbsz  = 1'($urandom_range(0, 1));
      raddr = (($urandom_range(0, 1) == 1) ? 16'hFFF8 : 16'h0400) + 16'($urandom_range(0, 7));
      rwd   = 16'($urandom);
      applyStimulus(rp, rwe, rbsz, raddr, rwd, o);
      modelApply(rp, rwe, rbsz, raddr, rwd, exp_rd, exp_err);
      checkOutput($sformatf("rand%0d latency", i), 32'(o.lat), exp_err ? 32'd1 : (rwe ? 32'd2 : 32'd3));
      checkOutput($sformatf("rand%0d err", i), 32'(o.err), 32'(exp_err));
      checkOutput($sformatf("rand%0d rdata", i), 32'(o.rdata), 32'(exp_rd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
